// File: rtl/led_pkg.sv
// Shared mode encoding and LED pattern constants for the LED sequencer.
// Mode stepping and per-mode entry patterns live here so every block agrees on them.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_ALL    = 3'b111;
  localparam logic [2:0] CHASE_INIT = 3'b001;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:   return MODE_ON;
      MODE_ON:    return MODE_BLINK;
      MODE_BLINK: return MODE_CHASE;
      default:    return MODE_OFF;
    endcase
  endfunction

  function automatic logic [2:0] entry_pattern(input mode_t m);
    case (m)
      MODE_OFF:   return LED_OFF;
      MODE_ON:    return LED_ALL;
      MODE_BLINK: return LED_ALL;
      default:    return CHASE_INIT;
    endcase
  endfunction

  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, stable-level debouncer and a
// one-cycle pulse on each accepted press (debounced level falling 1->0).
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             key_meta;
  logic             key_s;
  logic             key_db;
  logic             key_db_d;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      key_meta <= key;
      key_s    <= key_meta;
      // Press is taken from the registered copy so it lands one cycle after key_db falls.
      key_db_d <= key_db;
      press    <= key_db_d & ~key_db;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: each debounced press walks OFF -> ON -> BLINK -> CHASE -> OFF;
// a free-running step timer animates BLINK (invert) and CHASE (rotate left).
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int STEP_CYC     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       press
);

  localparam int STEP_W = $clog2(STEP_CYC);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

  logic              press_i;
  logic              tick;
  mode_t             mode_q;
  logic [2:0]        led_q;
  logic [STEP_W-1:0] step_cnt;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .press(press_i)
  );

  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      led_q    <= LED_OFF;
      step_cnt <= '0;
    end else if (press_i) begin
      // A press wins over a coinciding tick: the new mode starts from its entry pattern.
      mode_q   <= next_mode(mode_q);
      led_q    <= entry_pattern(next_mode(mode_q));
      step_cnt <= '0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + STEP_W'(1);
      if (tick) begin
        case (mode_q)
          MODE_BLINK: led_q <= ~led_q;
          MODE_CHASE: led_q <= rotl3(led_q);
          default:    led_q <= led_q;
        endcase
      end
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign press = press_i;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with DEBOUNCE_CYC=4, STEP_CYC=8: directed scenarios
// followed by random key activity, all checked every cycle against a timing model.
module tb_led_seq_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [2:0] led;
  logic [1:0] mode;
  logic       press;

  int vectors     = 0;
  int miscompares = 0;

  led_seq_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .STEP_CYC    (STEP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .led  (led),
    .mode (mode),
    .press(press)
  );

  always #5 clk = ~clk;

  // Model: key reaches the debouncer two edges late; a level is accepted once the
  // last DEB synchronised samples all differ from it; led is a function of the mode
  // and how many whole STEP periods have elapsed since that mode was entered.
  bit m_p0 = 1'b1, m_p1 = 1'b1;
  bit m_db = 1'b1, m_db_d = 1'b1, m_press = 1'b0;
  int m_mode = 0;
  int m_age = 0;
  bit win[$];

  always @(posedge clk) begin : model
    bit ks;
    bit all_diff;
    if (rst) begin
      m_p0 = 1'b1; m_p1 = 1'b1;
      m_db = 1'b1; m_db_d = 1'b1; m_press = 1'b0;
      m_mode = 0; m_age = 0;
      win.delete();
    end else begin
      ks = m_p1;
      if (m_press) begin
        m_mode = (m_mode + 1) % 4;
        m_age  = 0;
      end else begin
        m_age++;
      end
      m_press = m_db_d && !m_db;
      m_db_d  = m_db;
      win.push_back(ks);
      if (win.size() > DEB) void'(win.pop_front());
      all_diff = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = ks;
      m_p1 = m_p0;
      m_p0 = key;
    end
  end

  function automatic int exp_led(input int md, input int age);
    case (md)
      0:       return 0;
      1:       return 7;
      2:       return (((age / STEP) % 2) == 1) ? 0 : 7;
      default: return 1 << ((age / STEP) % 3);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample on the falling edge and compare against the model.
  task automatic step();
    @(negedge clk);
    check("model_led",   int'(led),   exp_led(m_mode, m_age));
    check("model_mode",  int'(mode),  m_mode);
    check("model_press", int'(press), int'(m_press));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold key low until the resulting mode change is visible (entry cycle, age 0).
  task automatic do_press();
    key = 1'b0;
    steps(8);
  endtask

  task automatic release_key(input int n);
    key = 1'b1;
    steps(n);
  endtask

  initial begin
    // Reset held with key low.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", int'(led), 0);
      check("rst_mode", int'(mode), 0);
      check("rst_press", int'(press), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_press", int'(press), 0);
    end
    release_key(20);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(10);
    check("clean_start_mode", int'(mode), 0);

    // Clean press: pulse exactly 7 cycles after the key edge, mode/led one later.
    key = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("press_early", int'(press), 0);
    end
    step();
    check("press_at_7", int'(press), 1);
    step();
    check("press_width", int'(press), 0);
    check("on_mode", int'(mode), 1);
    check("on_led", int'(led), 7);
    steps(2);
    release_key(12);

    // Glitch shorter than the debounce window.
    key = 1'b0;
    steps(3);
    release_key(15);
    check("glitch_mode", int'(mode), 1);

    // Mode walk from OFF.
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(10);
    do_press();
    check("walk_on", int'(mode), 1);
    release_key(20);
    do_press();
    check("walk_blink_mode", int'(mode), 2);
    check("walk_blink_led0", int'(led), 7);
    release_key(8);
    check("walk_blink_led1", int'(led), 0);
    steps(8);
    check("walk_blink_led2", int'(led), 7);
    steps(4);
    do_press();
    check("walk_chase_mode", int'(mode), 3);
    check("walk_chase_led0", int'(led), 1);
    release_key(8);
    check("walk_chase_led1", int'(led), 2);
    steps(8);
    check("walk_chase_led2", int'(led), 4);
    steps(8);
    check("walk_chase_led3", int'(led), 1);
    do_press();
    check("walk_off_mode", int'(mode), 0);
    check("walk_off_led", int'(led), 0);
    release_key(20);

    // Press coinciding with a tick in BLINK.
    do_press();
    release_key(20);
    do_press();
    check("coll_blink", int'(mode), 2);
    release_key(16);
    key = 1'b0;
    steps(7);
    check("coll_press", int'(press), 1);
    check("coll_led_before", int'(led), 7);
    step();
    check("coll_mode", int'(mode), 3);
    check("coll_led", int'(led), 1);

    // Reset in the middle of CHASE with led=100.
    release_key(16);
    check("mid_led_100", int'(led), 4);
    rst = 1'b1;
    step();
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_press", int'(press), 0);
    rst = 1'b0;
    steps(10);
    do_press();
    release_key(20);
    do_press();
    release_key(8);
    check("mid_blink_toggle", int'(led), 0);

    // Random key activity with occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      key = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      steps($urandom_range(1, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
